cdb_arbiter: RTL and testbench

Parametrised common-data-bus stage for the Tomasulo core. It arbitrates round-robin among N_CH functional-unit result channels and broadcasts one result per cycle (tag + data) to the reservation stations. It owns the register status table (Qi per FP register) and drives the FP register file write port only when the broadcasting tag is still the register's current producer.

---
 rtl/cdb_arbiter.sv | 113 +++++++++++
 tb/tb_cdb_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus stage: round-robin pick of one FU result per cycle, broadcast,
// and register-status (Qi) bookkeeping with a guarded FP register-file write.
module cdb_arbiter #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned TAG_W  = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH-1:0]          ch_valid,
  output logic [N_CH-1:0]          ch_ready,
  input  logic [N_CH*TAG_W-1:0]    ch_tag,
  input  logic [N_CH*REG_AW-1:0]   ch_dest,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  input  logic                     issue_en,
  input  logic [REG_AW-1:0]        issue_dest,
  input  logic [TAG_W-1:0]         issue_tag,
  input  logic [REG_AW-1:0]        qi_rd_addr,
  output logic [TAG_W-1:0]         qi_rd_tag,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [DATA_W-1:0]        cdb_data,
  output logic                     rf_we,
  output logic [REG_AW-1:0]        rf_addr,
  output logic [DATA_W-1:0]        rf_data,
  output logic [15:0]              cdb_count
);

  localparam int unsigned PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned N_REG = 2 ** REG_AW;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  grantIdx;
  logic [PTR_W-1:0]  candIdx;
  logic              grantAny;
  logic [TAG_W-1:0]  grantTag;
  logic [REG_AW-1:0] grantDest;
  logic [DATA_W-1:0] grantData;
  logic              producerMatch;
  logic [TAG_W-1:0]  qiTable [N_REG];

  // Round-robin search starting just after the last granted channel.
  always_comb begin : pick
    grantAny = 1'b0;
    grantIdx = ptr;
    candIdx  = ptr;
    ch_ready = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      candIdx = PTR_W'((32'(ptr) + k) % N_CH);
      if (!grantAny && ch_valid[candIdx]) begin
        grantAny = 1'b1;
        grantIdx = candIdx;
      end
    end
    if (reset) grantAny = 1'b0;
    if (grantAny) ch_ready[grantIdx] = 1'b1;
  end

  always_comb begin : select
    grantTag  = '0;
    grantDest = '0;
    grantData = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (PTR_W'(i) == grantIdx) begin
        grantTag  = ch_tag[i*TAG_W +: TAG_W];
        grantDest = ch_dest[i*REG_AW +: REG_AW];
        grantData = ch_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Write back only if this tag is still the register's most recent producer.
  assign producerMatch = grantAny && (grantDest != '0) && (grantTag != '0) &&
                         (qiTable[grantDest] == grantTag);
  assign qi_rd_tag = qiTable[qi_rd_addr];

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr       <= PTR_W'(N_CH - 1);
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      rf_we     <= 1'b0;
      rf_addr   <= '0;
      rf_data   <= '0;
      cdb_count <= '0;
      for (int unsigned r = 0; r < N_REG; r++) qiTable[r] <= '0;
    end else begin
      cdb_valid <= grantAny;
      cdb_tag   <= grantAny ? grantTag : '0;
      cdb_data  <= grantAny ? grantData : '0;
      rf_we     <= producerMatch;
      rf_addr   <= producerMatch ? grantDest : '0;
      rf_data   <= producerMatch ? grantData : '0;
      if (grantAny) begin
        ptr       <= grantIdx;
        cdb_count <= cdb_count + 16'd1;
      end
      if (producerMatch) qiTable[grantDest] <= '0;
      // Later assignment: a same-edge rename overrides the clear.
      if (issue_en && (issue_dest != '0)) qiTable[issue_dest] <= issue_tag;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : gChk
    aHoldValid: assert property (@(posedge clock) disable iff (reset)
      (ch_valid[i] && !ch_ready[i]) |=> ch_valid[i]);
    aNonZeroTag: assert property (@(posedge clock) disable iff (reset)
      ch_valid[i] |-> (ch_tag[i*TAG_W +: TAG_W] != '0));
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model of the arbitration and register-status rules.
module tb_cdb_arbiter;
  localparam int N = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  ch_valid, ch_ready;
  logic [11:0] ch_tag, ch_dest;
  logic [63:0] ch_data;
  logic        issue_en;
  logic [2:0]  issue_dest, issue_tag, qi_rd_addr, qi_rd_tag;
  logic        cdb_valid, rf_we;
  logic [2:0]  cdb_tag, rf_addr;
  logic [15:0] cdb_data, rf_data, cdb_count;

  always #5 clock = ~clock;

  cdb_arbiter #(.N_CH(4), .DATA_W(16), .REG_AW(3), .TAG_W(3)) dut (
    .clock(clock), .reset(reset),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_tag(ch_tag), .ch_dest(ch_dest),
    .ch_data(ch_data), .issue_en(issue_en), .issue_dest(issue_dest),
    .issue_tag(issue_tag), .qi_rd_addr(qi_rd_addr), .qi_rd_tag(qi_rd_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .cdb_count(cdb_count)
  );

  logic        cValid [N];
  logic [2:0]  cTag   [N];
  logic [2:0]  cDest  [N];
  logic [15:0] cData  [N];

  always_comb begin
    ch_valid = '0;
    ch_tag   = '0;
    ch_dest  = '0;
    ch_data  = '0;
    for (int i = 0; i < N; i++) begin
      ch_valid[i]        = cValid[i];
      ch_tag[i*3 +: 3]   = cTag[i];
      ch_dest[i*3 +: 3]  = cDest[i];
      ch_data[i*16 +: 16] = cData[i];
    end
  end

  wire [55:0] outVec = {cdb_valid, cdb_tag, cdb_data, rf_we, rf_addr, rf_data, cdb_count};

  // Reference model state and per-cycle expectations
  int          mQi [8];
  int          mPtr, mCount, mGrant;
  logic [55:0] expOut;
  logic [3:0]  expReady, obsReady;
  int          expQi;
  logic [2:0]  obsQi;
  int          total = 0;
  int          bad = 0;

  // One clock: sample combinational outputs mid-cycle, advance model, land #1 after posedge.
  task automatic tick();
    int c, t, d, dat;
    bit wr;
    @(negedge clock);
    obsReady = ch_ready;
    obsQi    = qi_rd_tag;
    expQi    = mQi[qi_rd_addr];
    mGrant   = -1;
    if (!reset)
      for (int k = 1; k <= N; k++) begin
        c = (mPtr + k) % N;
        if (mGrant < 0 && cValid[c]) mGrant = c;
      end
    expReady = (mGrant >= 0) ? 4'(1 << mGrant) : 4'b0;
    if (reset) begin
      for (int r = 0; r < 8; r++) mQi[r] = 0;
      mPtr = N - 1;
      mCount = 0;
      expOut = '0;
    end else begin
      if (mGrant >= 0) begin
        t = int'(cTag[mGrant]);
        d = int'(cDest[mGrant]);
        dat = int'(cData[mGrant]);
        wr = (d != 0) && (t != 0) && (mQi[d] == t);
        mCount = (mCount + 1) % 65536;
        mPtr = mGrant;
        expOut = {1'b1, 3'(t), 16'(dat), wr, wr ? 3'(d) : 3'd0, wr ? 16'(dat) : 16'd0, 16'(mCount)};
        if (wr) mQi[d] = 0;
      end else begin
        expOut = {40'd0, 16'(mCount)};
      end
      if (issue_en && issue_dest != 3'd0) mQi[issue_dest] = int'(issue_tag);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while ((cValid[0] || cValid[1] || cValid[2] || cValid[3]) && guard < 20) begin
      tick();
      if (mGrant >= 0) cValid[mGrant] = 1'b0;
      guard++;
    end
    total++;
    if (guard >= 20) begin
      bad++;
      $display("FAIL drain_timeout valid=%b still pending after %0d cycles", ch_valid, guard);
    end
  endtask

  task automatic setCh(input int c, input logic [2:0] t, input logic [2:0] d, input logic [15:0] v);
    cValid[c] = 1'b1;
    cTag[c] = t;
    cDest[c] = d;
    cData[c] = v;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    qi_rd_addr = 3'd3;
    doReset();
    total++;
    if (outVec !== 56'd0) begin bad++; $display("FAIL reset_out got=%h want=0", outVec); end
    total++;
    if (obsReady !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b want=0000", obsReady); end
    total++;
    if (obsQi !== 3'd0) begin bad++; $display("FAIL reset_qi got=%0d want=0", obsQi); end
  endtask

  task automatic test_basic();
    issue_en = 1'b1; issue_dest = 3'd3; issue_tag = 3'd2;
    tick();
    issue_en = 1'b0;
    setCh(0, 3'd2, 3'd3, 16'h00AA);
    tick();
    cValid[0] = 1'b0;
    total++;
    if (outVec !== {1'b1, 3'd2, 16'h00AA, 1'b1, 3'd3, 16'h00AA, 16'd1}) begin
      bad++; $display("FAIL basic_bcast got=%h want=%h", outVec,
                      {1'b1, 3'd2, 16'h00AA, 1'b1, 3'd3, 16'h00AA, 16'd1});
    end
    qi_rd_addr = 3'd3;
    tick();
    total++;
    if (obsQi !== 3'd0) begin bad++; $display("FAIL basic_qi_clear got=%0d want=0", obsQi); end
    total++;
    if (outVec !== {40'd0, 16'd1}) begin bad++; $display("FAIL basic_one_shot got=%h want=%h", outVec, {40'd0, 16'd1}); end
  endtask

  task automatic test_round_robin();
    doReset();
    for (int i = 0; i < N; i++) setCh(i, 3'(i + 1), 3'(i + 1), 16'(16'h0100 + i));
    for (int j = 0; j < 12; j++) begin
      tick();
      total++;
      if (obsReady !== 4'(1 << (j % N))) begin
        bad++; $display("FAIL rr_grant cyc%0d got=%b want=%b", j, obsReady, 4'(1 << (j % N)));
      end
      total++;
      if (cdb_valid !== 1'b1 || cdb_tag !== 3'(j % N + 1)) begin
        bad++; $display("FAIL rr_bcast cyc%0d got=%b/%0d want=1/%0d", j, cdb_valid, cdb_tag, j % N + 1);
      end
      if (j >= 8 && mGrant >= 0) cValid[mGrant] = 1'b0;
    end
    total++;
    if (cdb_count !== 16'd12) begin bad++; $display("FAIL rr_count got=%0d want=12", cdb_count); end
  endtask

  task automatic test_waw();
    issue_en = 1'b1; issue_dest = 3'd5; issue_tag = 3'd1;
    tick();
    issue_tag = 3'd4;
    tick();
    issue_en = 1'b0;
    setCh(1, 3'd1, 3'd5, 16'h1234);
    tick();
    cValid[1] = 1'b0;
    total++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 3'd1 || rf_we !== 1'b0) begin
      bad++; $display("FAIL waw_stale got=v%b t%0d we%b want=v1 t1 we0", cdb_valid, cdb_tag, rf_we);
    end
    qi_rd_addr = 3'd5;
    tick();
    total++;
    if (obsQi !== 3'd4) begin bad++; $display("FAIL waw_qi got=%0d want=4", obsQi); end
  endtask

  task automatic test_issue_vs_clear();
    issue_en = 1'b1; issue_dest = 3'd2; issue_tag = 3'd6;
    tick();
    issue_tag = 3'd7;
    setCh(0, 3'd6, 3'd2, 16'h5A5A);
    tick();
    cValid[0] = 1'b0;
    issue_en = 1'b0;
    total++;
    if (rf_we !== 1'b1 || rf_addr !== 3'd2 || rf_data !== 16'h5A5A) begin
      bad++; $display("FAIL same_edge_wr got=we%b a%0d d%h want=we1 a2 d5a5a", rf_we, rf_addr, rf_data);
    end
    qi_rd_addr = 3'd2;
    tick();
    total++;
    if (obsQi !== 3'd7) begin bad++; $display("FAIL same_edge_qi got=%0d want=7", obsQi); end
  endtask

  task automatic test_dest0();
    setCh(0, 3'd3, 3'd0, 16'h0007);
    tick();
    cValid[0] = 1'b0;
    total++;
    if (cdb_valid !== 1'b1 || rf_we !== 1'b0) begin
      bad++; $display("FAIL dest0_bcast got=v%b we%b want=v1 we0", cdb_valid, rf_we);
    end
    issue_en = 1'b1; issue_dest = 3'd0; issue_tag = 3'd5;
    tick();
    issue_en = 1'b0;
    qi_rd_addr = 3'd0;
    tick();
    total++;
    if (obsQi !== 3'd0) begin bad++; $display("FAIL dest0_issue got=%0d want=0", obsQi); end
  endtask

  task automatic test_reset_midflight();
    issue_en = 1'b1; issue_dest = 3'd4; issue_tag = 3'd3;
    tick();
    issue_en = 1'b0;
    setCh(2, 3'd5, 3'd1, 16'hBEEF);
    reset = 1'b1;
    tick();
    total++;
    if (obsReady !== 4'b0) begin bad++; $display("FAIL rst_ready got=%b want=0000", obsReady); end
    total++;
    if (outVec !== 56'd0) begin bad++; $display("FAIL rst_out got=%h want=0", outVec); end
    reset = 1'b0;
    qi_rd_addr = 3'd4;
    setCh(0, 3'd2, 3'd6, 16'h0011);
    tick();
    cValid[0] = 1'b0;
    total++;
    if (obsReady !== 4'b0001) begin bad++; $display("FAIL rst_prio got=%b want=0001", obsReady); end
    total++;
    if (obsQi !== 3'd0) begin bad++; $display("FAIL rst_qi got=%0d want=0", obsQi); end
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < N; c++) begin
        if (!cValid[c] || mGrant == c) begin
          cValid[c] = ($urandom_range(0, 2) != 0);
          cDest[c]  = 3'($urandom_range(0, 7));
          cTag[c]   = 3'($urandom_range(1, 7));
          cData[c]  = 16'($urandom);
          if ($urandom_range(0, 1) == 1 && mQi[cDest[c]] != 0) cTag[c] = 3'(mQi[cDest[c]]);
        end
      end
      issue_en   = ($urandom_range(0, 1) == 1);
      issue_dest = 3'($urandom_range(0, 7));
      issue_tag  = 3'($urandom_range(1, 7));
      qi_rd_addr = 3'($urandom_range(0, 7));
      tick();
      total++;
      if (obsReady !== expReady) begin bad++; $display("FAIL rnd_ready n%0d got=%b want=%b", n, obsReady, expReady); end
      total++;
      if (outVec !== expOut) begin bad++; $display("FAIL rnd_out n%0d got=%h want=%h", n, outVec, expOut); end
      total++;
      if (obsQi !== 3'(expQi)) begin bad++; $display("FAIL rnd_qi n%0d got=%0d want=%0d", n, obsQi, expQi); end
    end
    issue_en = 1'b0;
    for (int c = 0; c < N; c++) if (mGrant == c) cValid[c] = 1'b0;
    drain();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      cValid[i] = 1'b0; cTag[i] = '0; cDest[i] = '0; cData[i] = '0;
    end
    for (int r = 0; r < 8; r++) mQi[r] = 0;
    mPtr = N - 1; mCount = 0; mGrant = -1;
    issue_en = 1'b0; issue_dest = '0; issue_tag = '0; qi_rd_addr = '0;
    test_reset();
    test_basic();
    test_round_robin();
    test_waw();
    test_issue_vs_clear();
    test_dest0();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
